spi_master_gen: RTL and testbench

SPI_MASTER_GEN -- requirements
Module: spi_master_gen

---
 rtl/spi_master_gen_if.sv | 33 +++
 rtl/spi_master_gen.sv | 209 ++++++++++++++++++++
 tb/tb_spi_master_gen.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_gen_if.sv
// Bundled control, status and SPI pin signals of spi_master_gen.
// The master modport is the controller's view; slave is the host plus SPI slave side.
interface spi_master_gen_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 2,
  parameter int DIV_W  = 8
);
  logic              start;
  logic              ready;
  logic              busy;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic [DIV_W-1:0]  clk_div;
  logic [NUM_SS-1:0] ss_sel;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              done;
  logic              sclk;
  logic              mosi;
  logic [NUM_SS-1:0] ss_n;
  logic              miso;

  modport master (
    input  start, cpol, cpha, lsb_first, clk_div, ss_sel, tx_data, miso,
    output ready, busy, rx_data, done, sclk, mosi, ss_n
  );

  modport slave (
    output start, cpol, cpha, lsb_first, clk_div, ss_sel, tx_data, miso,
    input  ready, busy, rx_data, done, sclk, mosi, ss_n
  );
endinterface

// File: rtl/spi_master_gen.sv
// Single-word SPI master: configurable mode, bit order, SCLK divider and slave mask.
// All pin-level outputs come straight from flops.
module spi_master_gen #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 2,
  parameter int DIV_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  spi_master_gen_if.master bus
);
  localparam int IW = $clog2(DATA_W);
  localparam int HW = IW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HW-1:0]     hp_q, hp_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic [NUM_SS-1:0] ss_q, ss_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  logic              half_end_s;
  logic              last_hp_s;
  logic [IW-1:0]     idx_s;
  logic [IW-1:0]     idx_nxt_s;

  // Bit position idx of the transfer order maps to a word index via lsb.
  function automatic logic word_bit(input logic [DATA_W-1:0] w, input logic [IW-1:0] idx,
                                    input logic lsb);
    logic [IW-1:0] pos;
    pos = lsb ? idx : (IW'(DATA_W - 1) - idx);
    return w[pos];
  endfunction

  function automatic logic [DATA_W-1:0] put_bit(input logic [DATA_W-1:0] w,
                                                input logic [IW-1:0] idx,
                                                input logic lsb, input logic b);
    logic [IW-1:0]     pos;
    logic [DATA_W-1:0] r;
    pos    = lsb ? idx : (IW'(DATA_W - 1) - idx);
    r      = w;
    r[pos] = b;
    return r;
  endfunction

  assign half_end_s = (div_cnt_q == div_q);
  assign last_hp_s  = (hp_q == HW'(2 * DATA_W - 1));
  assign idx_s      = hp_q[IW:1];
  assign idx_nxt_s  = idx_s + 1'b1;

  // Next-state and output logic; each SHIFT half-period ends with one sclk toggle.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    div_d     = div_q;
    hp_d      = hp_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    ss_d      = ss_q;
    ss_n_d    = ss_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    ready_d   = 1'b0;

    case (state_q)
      IDLE: begin
        ss_n_d    = '1;
        mosi_d    = 1'b0;
        sclk_d    = bus.cpol;
        div_cnt_d = '0;
        hp_d      = '0;
        if (bus.start) begin
          state_d = SETUP;
          tx_d    = bus.tx_data;
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          lsb_d   = bus.lsb_first;
          div_d   = bus.clk_div;
          ss_d    = bus.ss_sel;
          ss_n_d  = ~bus.ss_sel;
          mosi_d  = word_bit(bus.tx_data, '0, bus.lsb_first);
          rx_sh_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (half_end_s) begin
          div_cnt_d = '0;
          state_d   = SHIFT;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (half_end_s) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          // Even half-periods end on a leading edge, odd ones on a trailing edge.
          if (!hp_q[0]) begin
            if (cpha_q) begin
              mosi_d = word_bit(tx_q, idx_s, lsb_q);
            end else begin
              rx_sh_d = put_bit(rx_sh_q, idx_s, lsb_q, bus.miso);
            end
          end else begin
            if (cpha_q) begin
              rx_sh_d = put_bit(rx_sh_q, idx_s, lsb_q, bus.miso);
            end else if (!last_hp_s) begin
              mosi_d = word_bit(tx_q, idx_nxt_s, lsb_q);
            end else begin
              mosi_d = mosi_q;
            end
          end
          if (last_hp_s) begin
            hp_d    = '0;
            state_d = HOLD;
          end else begin
            hp_d = hp_q + 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (half_end_s) begin
          div_cnt_d = '0;
          state_d   = IDLE;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          ss_n_d    = '1;
          mosi_d    = 1'b0;
          sclk_d    = bus.cpol;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      div_q     <= '0;
      hp_q      <= '0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      ss_q      <= '0;
      ss_n_q    <= '1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      div_q     <= div_d;
      hp_q      <= hp_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      ss_q      <= ss_d;
      ss_n_q    <= ss_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.busy    = ~ready_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.ss_n    = ss_n_q;
endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: a cycle-level timeline model of the transfer checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_spi_master_gen;
  localparam int N   = 8;
  localparam int NS  = 2;
  localparam int DVW = 8;
  localparam int OW  = 5 + NS + N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_gen_if #(.DATA_W(N), .NUM_SS(NS), .DIV_W(DVW)) bus();

  spi_master_gen #(.DATA_W(N), .NUM_SS(NS), .DIV_W(DVW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0, bad = 0;
  int cyc_checks = 0, cyc_bad = 0;

  logic         echo = 1'b1;
  logic [N-1:0] slave_word = '0;

  // Transfer timeline model: a word occupies cycles 1..L after the accept cycle,
  // L = H*(2N+2); cycle L+1 carries done.
  int            cyc = 0, m_c0 = 0, m_h = 1;
  logic          m_active = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0, m_echo = 1'b1;
  logic [N-1:0]  m_tx = '0, m_sw = '0, rx_exp = '0;
  logic [NS-1:0] m_ss = '0;
  logic          cpol_prev = 1'b0;
  logic          m_ready;

  function automatic int xfer_len(input int h);
    return h * (2 * N + 2);
  endfunction

  assign m_ready = !m_active || ((cyc - m_c0) >= xfer_len(m_h) + 1);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active  <= 1'b0;
      cyc       <= 0;
      rx_exp    <= '0;
      cpol_prev <= 1'b0;
    end else begin
      cyc       <= cyc + 1;
      cpol_prev <= bus.cpol;
      if (m_active && (cyc - m_c0) == xfer_len(m_h))
        rx_exp <= m_echo ? m_tx : m_sw;
      if (bus.start && m_ready) begin
        m_active <= 1'b1;
        m_c0     <= cyc;
        m_h      <= int'(bus.clk_div) + 1;
        m_tx     <= bus.tx_data;
        m_cpol   <= bus.cpol;
        m_cpha   <= bus.cpha;
        m_lsb    <= bus.lsb_first;
        m_ss     <= bus.ss_sel;
        m_echo   <= echo;
        m_sw     <= slave_word;
      end
    end
  end

  function automatic logic [OW-1:0] model_out();
    int t, h, L, k, idx;
    logic rdy, dn, sc, mo;
    logic [NS-1:0] sn;
    logic [N-1:0] sh;
    h = m_h; L = xfer_len(h); t = cyc - m_c0;
    rdy = 1'b1; dn = 1'b0; sc = cpol_prev; mo = 1'b0; sn = '1;
    if (m_active && t >= 1 && t <= L) begin
      rdy = 1'b0; sn = ~m_ss; sc = m_cpol; idx = 0;
      if (t > h && t <= h + 2 * N * h) begin
        k   = (t - h - 1) / h;
        sc  = m_cpol ^ k[0];
        idx = m_cpha ? ((k + 1) / 2 - 1) : (k / 2);
        if (idx < 0) idx = 0;
        if (idx > N - 1) idx = N - 1;
      end else if (t > h + 2 * N * h) begin
        idx = N - 1;
      end
      if (m_lsb) begin
        sh = m_tx >> idx; mo = sh[0];
      end else begin
        sh = m_tx << idx; mo = sh[N-1];
      end
    end
    if (m_active && t == L + 1) dn = 1'b1;
    return {rdy, ~rdy, dn, sc, mo, sn, rx_exp};
  endfunction

  // Slave returning slave_word, advancing one bit per sampling edge it observes.
  int           samp_idx = 0;
  logic [N-1:0] sw_l, sw_m;
  assign sw_l     = slave_word >> samp_idx;
  assign sw_m     = slave_word << samp_idx;
  assign bus.miso = echo ? bus.mosi : (m_lsb ? sw_l[0] : sw_m[N-1]);

  logic         sclk_last = 1'b0;
  logic [N-1:0] cap = '0;
  int tog_last = 0, tog_prev = 0, done_cnt = 0, done_cyc = 0, ss1_hi = 0, ss0_lo = 0;

  always @(negedge clk) begin : mon
    int t;
    t = cyc - m_c0;
    sclk_last <= bus.sclk;
    if (bus.sclk != sclk_last) begin
      tog_prev <= tog_last;
      tog_last <= cyc;
    end
    if (m_active && t == 1) begin
      samp_idx <= 0;
    end else if (m_active && bus.sclk != sclk_last && t >= m_h + 1 && t <= m_h + 2 * N * m_h + 1) begin
      if (m_cpha ? (bus.sclk == m_cpol) : (bus.sclk != m_cpol)) begin
        samp_idx <= samp_idx + 1;
        cap      <= {cap[N-2:0], bus.mosi};
      end
    end
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    ss1_hi <= ss1_hi + int'(bus.ss_n[1]);
    ss0_lo <= ss0_lo + int'(!bus.ss_n[0]);
  end

  always @(negedge clk) begin : cmp
    logic [OW-1:0] act, expv;
    if (!rst) begin
      expv = model_out();
      act  = {bus.ready, bus.busy, bus.done, bus.sclk, bus.mosi, bus.ss_n, bus.rx_data};
      cyc_checks <= cyc_checks + 1;
      if (act !== expv) begin
        cyc_bad <= cyc_bad + 1;
        $display("FAIL cycle_check cyc=%0d got %h want %h", cyc, act, expv);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [N-1:0] tx, input logic pol, input logic pha,
                            input logic lsb, input logic [DVW-1:0] dv, input logic [NS-1:0] ss,
                            input logic ech, input logic [N-1:0] sw, output int acc);
    tick();
    bus.tx_data = tx; bus.cpol = pol; bus.cpha = pha; bus.lsb_first = lsb;
    bus.clk_div = dv; bus.ss_sel = ss; echo = ech; slave_word = sw;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    acc = cyc - 1;
  endtask

  task automatic wait_done(output int dcyc);
    int n, d0;
    n = 0; d0 = done_cnt;
    while (done_cnt == d0 && n < 6000) begin
      tick();
      n++;
    end
    if (done_cnt == d0) begin
      total++; bad++;
      $display("FAIL wait_done: got no done within %0d cycles", n);
    end
    dcyc = done_cyc;
  endtask

  initial begin
    int acc, d1, d2, s1, s2, z0, dn0;
    logic pol, pha;
    bus.start = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb_first = 1'b0;
    bus.clk_div = '0; bus.ss_sel = '0; bus.tx_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out", 32'({bus.ready, bus.busy, bus.done, bus.sclk, bus.mosi, bus.ss_n, bus.rx_data}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8'h00}));
    rst = 1'b0;

    // Mode 0, 0xA5 out, slave answers 0x3C.
    start_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 8'd0, 2'b01, 1'b0, 8'h3C, acc);
    wait_done(d1);
    chk("a5_latency", 32'(d1 - acc), 32'd19);
    chk("a5_mosi_bits", 32'(cap), 32'h0A5);
    tick();
    chk("a5_rx", 32'(bus.rx_data), 32'h3C);

    // All four modes, H=4, echoing slave.
    for (int m = 0; m < 4; m++) begin
      pol = m[1]; pha = m[0];
      tick(); bus.cpol = pol;
      tick(); tick();
      chk("mode_idle_sclk", 32'(bus.sclk), 32'(pol));
      start_xfer(8'h81, pol, pha, 1'b0, 8'd3, 2'b01, 1'b1, 8'h00, acc);
      wait_done(d1);
      chk("mode_half_period", 32'(tog_last - tog_prev), 32'd4);
      chk("mode_rx", 32'(bus.rx_data), 32'h81);
    end

    // LSB-first: 0x01 leads with a 1; slave returns 0x80.
    start_xfer(8'h01, 1'b0, 1'b0, 1'b1, 8'd0, 2'b01, 1'b0, 8'h80, acc);
    chk("lsb_first_bit", 32'(bus.mosi), 32'd1);
    wait_done(d1);
    chk("lsb_rx", 32'(bus.rx_data), 32'h80);

    // Back-to-back with start held high.
    z0 = ss0_lo;
    tick();
    bus.tx_data = 8'h12; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb_first = 1'b0;
    bus.clk_div = 8'd0; bus.ss_sel = 2'b10; echo = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.tx_data = 8'h34;
    s1 = ss1_hi;
    wait_done(d1);
    tick();
    bus.start = 1'b0;
    s2 = ss1_hi;
    wait_done(d2);
    chk("b2b_spacing", 32'(d2 - d1), 32'd19);
    chk("b2b_ss1_gap", 32'(s2 - s1), 32'd1);
    chk("b2b_ss0_low", 32'(ss0_lo - z0), 32'd0);
    chk("b2b_rx2", 32'(bus.rx_data), 32'h34);

    // Reset in the middle of SHIFT.
    start_xfer(8'h6B, 1'b0, 1'b0, 1'b0, 8'd0, 2'b01, 1'b1, 8'h00, acc);
    repeat (9) tick();
    dn0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("midrst_out", 32'({bus.ready, bus.busy, bus.done, bus.sclk, bus.mosi, bus.ss_n, bus.rx_data}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8'h00}));
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("midrst_no_done", 32'(done_cnt - dn0), 32'd0);
    chk("midrst_rx", 32'(bus.rx_data), 32'h00);
    start_xfer(8'h5A, 1'b0, 1'b0, 1'b0, 8'd0, 2'b01, 1'b1, 8'h00, acc);
    wait_done(d1);
    chk("after_rst_rx", 32'(bus.rx_data), 32'h5A);

    // Inputs changed mid-transfer and start pulsed while busy.
    start_xfer(8'hC3, 1'b0, 1'b0, 1'b0, 8'd1, 2'b01, 1'b1, 8'h00, acc);
    dn0 = done_cnt;
    repeat (12) tick();
    bus.tx_data = 8'hFF; bus.cpol = 1'b1; bus.clk_div = 8'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(d1);
    chk("latched_latency", 32'(d1 - acc), 32'd37);
    repeat (4) tick();
    chk("busy_start_ignored", 32'(done_cnt - dn0), 32'd1);
    chk("busy_start_ready", 32'(bus.ready), 32'd1);
    chk("latched_rx", 32'(bus.rx_data), 32'hC3);
    bus.cpol = 1'b0;

    // Maximum divider with no slave selected.
    start_xfer(8'h96, 1'b0, 1'b1, 1'b0, 8'hFF, 2'b00, 1'b1, 8'h00, acc);
    wait_done(d1);
    chk("maxdiv_latency", 32'(d1 - acc), 32'd4609);
    chk("maxdiv_rx", 32'(bus.rx_data), 32'h96);

    repeat (3) tick();
    total = total + cyc_checks;
    bad   = bad + cyc_bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
